// File: rtl/canvas_pkg.sv
// Shared constants and FSM encoding for the canvas writer and its stamp sequencer.
package canvas_pkg;

    localparam int SIDE_LOG2_DEF = 5;
    localparam int ADDR_W        = 2 * SIDE_LOG2_DEF;
    localparam int PIXELS        = 1 << ADDR_W;
    localparam int BRUSH_TAPS    = 9;
    localparam int IDX_W         = 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_STAMP,
        S_CLEAR,
        S_SUBMIT
    } state_t;

endpackage

// File: rtl/canvas_writer_stamp_sequencer.sv
// Brush walker: maps a brush tap index onto a canvas address around the latched centre,
// flagging taps that fall off the canvas edge.
module stamp_sequencer
    import canvas_pkg::*;
#(
    parameter int SIDE_LOG2 = SIDE_LOG2_DEF
) (
    input  logic                   start,
    input  logic [IDX_W-1:0]       cur_idx,
    input  logic [SIDE_LOG2-1:0]   centre_x,
    input  logic [SIDE_LOG2-1:0]   centre_y,
    input  logic                   big,
    output logic [IDX_W-1:0]       idx,
    output logic                   in_range,
    output logic [2*SIDE_LOG2-1:0] addr,
    output logic                   done
);

    logic signed [1:0]           dx;
    logic signed [1:0]           dy;
    logic signed [SIDE_LOG2+1:0] px;
    logic signed [SIDE_LOG2+1:0] py;

    always_comb begin
        idx = start ? '0 : cur_idx + IDX_W'(1);
        dx  = 2'sd0;
        dy  = 2'sd0;
        if (big) begin
            if (idx < 4'd3) begin
                dy = -2'sd1;
            end else if (idx > 4'd5) begin
                dy = 2'sd1;
            end
            case (idx)
                4'd0, 4'd3, 4'd6: dx = -2'sd1;
                4'd2, 4'd5, 4'd8: dx = 2'sd1;
                default:          dx = 2'sd0;
            endcase
        end
        // Two guard bits catch both -1 and 2^SIDE_LOG2, so no coordinate can wrap.
        px       = $signed({2'b00, centre_x}) + (SIDE_LOG2+2)'(dx);
        py       = $signed({2'b00, centre_y}) + (SIDE_LOG2+2)'(dy);
        in_range = (px[SIDE_LOG2+1:SIDE_LOG2] == 2'b00) && (py[SIDE_LOG2+1:SIDE_LOG2] == 2'b00);
        addr     = {py[SIDE_LOG2-1:0], px[SIDE_LOG2-1:0]};
        done     = big ? (idx == IDX_W'(BRUSH_TAPS - 1)) : 1'b1;
    end

endmodule

// File: rtl/canvas_writer.sv
// Drawing front end: turns pen, clear and submit requests into writes to a 1-bit canvas RAM
// and a completion pulse for the recognizer.
module canvas_writer
    import canvas_pkg::*;
#(
    parameter int SIDE_LOG2 = SIDE_LOG2_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [SIDE_LOG2-1:0]   cursor_x,
    input  logic [SIDE_LOG2-1:0]   cursor_y,
    input  logic                   pen_down,
    input  logic                   erase,
    input  logic                   brush_big,
    input  logic                   clear_req,
    input  logic                   submit_req,
    output logic [2*SIDE_LOG2-1:0] wr_addr,
    output logic                   wr_en,
    output logic                   wr_data,
    output logic                   end_write,
    output logic                   busy
);

    localparam int AW = 2 * SIDE_LOG2;

    state_t               state_q, state_d;
    logic [SIDE_LOG2-1:0] cx_q, cx_d, cy_q, cy_d;
    logic                 erase_q, erase_d, big_q, big_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic                 last_q, last_d;
    logic [AW-1:0]        sweep_q, sweep_d;
    logic                 pend_q, pend_d;
    logic                 wr_en_q, wr_en_d, wr_data_q, wr_data_d, end_write_q, end_write_d;
    logic [AW-1:0]        wr_addr_q, wr_addr_d;

    logic                 start;
    logic [SIDE_LOG2-1:0] seq_cx, seq_cy;
    logic                 seq_big, seq_erase;
    logic [IDX_W-1:0]     seq_idx;
    logic                 seq_in_range, seq_done;
    logic [AW-1:0]        seq_addr;
    logic                 do_stamp, do_clear, do_finish;

    // The first tap is issued on the entry edge, so it reads live inputs; later taps read the latch.
    assign start     = (state_q == S_IDLE);
    assign seq_cx    = start ? cursor_x  : cx_q;
    assign seq_cy    = start ? cursor_y  : cy_q;
    assign seq_big   = start ? brush_big : big_q;
    assign seq_erase = start ? erase     : erase_q;

    stamp_sequencer #(
        .SIDE_LOG2(SIDE_LOG2)
    ) u_seq (
        .start    (start),
        .cur_idx  (idx_q),
        .centre_x (seq_cx),
        .centre_y (seq_cy),
        .big      (seq_big),
        .idx      (seq_idx),
        .in_range (seq_in_range),
        .addr     (seq_addr),
        .done     (seq_done)
    );

    always_comb begin
        state_d     = state_q;
        cx_d        = cx_q;
        cy_d        = cy_q;
        erase_d     = erase_q;
        big_d       = big_q;
        idx_d       = idx_q;
        last_d      = last_q;
        sweep_d     = sweep_q;
        pend_d      = pend_q | submit_req;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        end_write_d = 1'b0;
        do_stamp    = 1'b0;
        do_clear    = 1'b0;
        do_finish   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (clear_req) begin
                    do_clear = 1'b1;
                end else if (pend_q || submit_req) begin
                    do_finish = 1'b1;
                end else if (pen_down) begin
                    cx_d     = cursor_x;
                    cy_d     = cursor_y;
                    erase_d  = erase;
                    big_d    = brush_big;
                    do_stamp = 1'b1;
                end
            end
            S_STAMP: begin
                if (clear_req) begin
                    do_clear = 1'b1;
                end else if (last_q) begin
                    do_finish = 1'b1;
                end else begin
                    do_stamp = 1'b1;
                end
            end
            S_CLEAR: begin
                if (sweep_q == '1) begin
                    do_finish = 1'b1;
                end else begin
                    sweep_d   = sweep_q + AW'(1);
                    wr_en_d   = 1'b1;
                    wr_addr_d = sweep_d;
                    wr_data_d = 1'b0;
                end
            end
            S_SUBMIT: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase

        if (do_clear) begin
            state_d   = S_CLEAR;
            sweep_d   = '0;
            wr_en_d   = 1'b1;
            wr_addr_d = '0;
            wr_data_d = 1'b0;
        end
        if (do_stamp) begin
            state_d = S_STAMP;
            idx_d   = seq_idx;
            last_d  = seq_done;
            if (seq_in_range) begin
                wr_en_d   = 1'b1;
                wr_addr_d = seq_addr;
                wr_data_d = ~seq_erase;
            end
        end
        // A pending submit goes straight out when an operation ends, without an idle gap.
        if (do_finish) begin
            if (pend_d) begin
                state_d     = S_SUBMIT;
                end_write_d = 1'b1;
                pend_d      = 1'b0;
            end else begin
                state_d = S_IDLE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cx_q        <= '0;
            cy_q        <= '0;
            erase_q     <= 1'b0;
            big_q       <= 1'b0;
            idx_q       <= '0;
            last_q      <= 1'b0;
            sweep_q     <= '0;
            pend_q      <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= 1'b0;
            end_write_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cx_q        <= cx_d;
            cy_q        <= cy_d;
            erase_q     <= erase_d;
            big_q       <= big_d;
            idx_q       <= idx_d;
            last_q      <= last_d;
            sweep_q     <= sweep_d;
            pend_q      <= pend_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            end_write_q <= end_write_d;
        end
    end

    assign wr_addr   = wr_addr_q;
    assign wr_en     = wr_en_q;
    assign wr_data   = wr_data_q;
    assign end_write = end_write_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_canvas_writer.sv
// Directed bench for canvas_writer: reset, clear sweep, brush stamps at canvas corners,
// held pen, submit coalescing, stamp abort and asynchronous reset mid-sweep.
module tb_canvas_writer;

    localparam int S  = 5;
    localparam int AW = 2 * S;

    logic          clk;
    logic          rst;
    logic [S-1:0]  cursor_x, cursor_y;
    logic          pen_down, erase, brush_big, clear_req, submit_req;
    logic [AW-1:0] wr_addr;
    logic          wr_en, wr_data, end_write, busy;

    int n_assert = 0;
    int n_fail   = 0;
    int errs;
    int last_wr, last_addr, ew_cnt, ew_cyc, ew_wr;

    int t37_en[9]   = '{0, 0, 0, 0, 1, 1, 0, 1, 1};
    int t37_addr[9] = '{101, 101, 101, 101, 0, 1, 1, 32, 33};
    int t38_en[9]   = '{1, 1, 0, 1, 1, 0, 0, 0, 0};
    int t38_addr[9] = '{990, 991, 991, 1022, 1023, 1023, 1023, 1023, 1023};

    canvas_writer #(.SIDE_LOG2(S)) dut (
        .clk        (clk),
        .rst        (rst),
        .cursor_x   (cursor_x),
        .cursor_y   (cursor_y),
        .pen_down   (pen_down),
        .erase      (erase),
        .brush_big  (brush_big),
        .clear_req  (clear_req),
        .submit_req (submit_req),
        .wr_addr    (wr_addr),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .end_write  (end_write),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; cursor_x = '0; cursor_y = '0; pen_down = 1'b0; erase = 1'b0;
        brush_big = 1'b0; clear_req = 1'b0; submit_req = 1'b0;
        step(); step();
        chk("rst_wr_en", wr_en, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_end_write", end_write, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;
        step();

        // full clear sweep
        clear_req = 1'b1; step(); clear_req = 1'b0;
        chk("clr_busy_rise", busy, 1);
        errs = 0;
        for (int i = 0; i < 1024; i++) begin
            if (!(wr_en === 1'b1 && wr_addr === i[AW-1:0] && wr_data === 1'b0)) errs++;
            step();
        end
        chk("clr_sweep_errs", errs, 0);
        chk("clr_end_wr_en", wr_en, 0);
        chk("clr_end_busy", busy, 0);
        chk("clr_addr_hold", wr_addr, 1023);

        // 1x1 pen at (5,3)
        cursor_x = 5; cursor_y = 3; pen_down = 1'b1; step(); pen_down = 1'b0;
        chk("dot_wr_en", wr_en, 1);
        chk("dot_addr", wr_addr, 101);
        chk("dot_data", wr_data, 1);
        step();
        chk("dot_after_en", wr_en, 0);
        chk("dot_after_busy", busy, 0);

        // 3x3 at (0,0); later input changes must be ignored
        cursor_x = 0; cursor_y = 0; brush_big = 1'b1; pen_down = 1'b1; step();
        pen_down = 1'b0; cursor_x = 10; cursor_y = 10; brush_big = 1'b0;
        for (int k = 0; k < 9; k++) begin
            chk($sformatf("b00_en%0d", k), wr_en, t37_en[k]);
            chk($sformatf("b00_addr%0d", k), wr_addr, t37_addr[k]);
            chk($sformatf("b00_busy%0d", k), busy, 1);
            step();
        end
        chk("b00_done_busy", busy, 0);

        // 3x3 erase at (31,31)
        cursor_x = 31; cursor_y = 31; brush_big = 1'b1; erase = 1'b1; pen_down = 1'b1; step();
        pen_down = 1'b0;
        for (int k = 0; k < 9; k++) begin
            chk($sformatf("b31_en%0d", k), wr_en, t38_en[k]);
            chk($sformatf("b31_addr%0d", k), wr_addr, t38_addr[k]);
            chk($sformatf("b31_data%0d", k), wr_data, 0);
            step();
        end
        chk("b31_done_busy", busy, 0);
        erase = 1'b0; brush_big = 1'b0;

        // held pen re-latches the cursor with one idle cycle between stamps
        cursor_x = 1; cursor_y = 2; pen_down = 1'b1; step();
        chk("held_a_en", wr_en, 1);
        chk("held_a_addr", wr_addr, 65);
        cursor_x = 3; step();
        chk("held_gap_en", wr_en, 0);
        chk("held_gap_busy", busy, 0);
        step();
        chk("held_b_en", wr_en, 1);
        chk("held_b_addr", wr_addr, 67);
        pen_down = 1'b0; step();

        // submits during a sweep coalesce into one end_write right after address 1023
        clear_req = 1'b1; step(); clear_req = 1'b0;
        repeat (100) step();
        chk("sub_at_addr", wr_addr, 100);
        submit_req = 1'b1; step(); submit_req = 1'b0;
        repeat (5) step();
        submit_req = 1'b1; step(); submit_req = 1'b0;
        last_wr = -1; last_addr = -1; ew_cnt = 0; ew_cyc = -1; ew_wr = -1;
        for (int n = 0; n < 1200; n++) begin
            if (wr_en) begin last_wr = n; last_addr = int'(wr_addr); end
            if (end_write) begin ew_cnt++; ew_cyc = n; ew_wr = int'(wr_en); end
            step();
        end
        chk("sub_ew_count", ew_cnt, 1);
        chk("sub_ew_cycle", ew_cyc, last_wr + 1);
        chk("sub_ew_wr_en", ew_wr, 0);
        chk("sub_last_addr", last_addr, 1023);

        // clear aborts a 3x3 stamp after its current tap
        cursor_x = 5; cursor_y = 5; brush_big = 1'b1; pen_down = 1'b1; step();
        pen_down = 1'b0; brush_big = 1'b0;
        chk("abt_t0_en", wr_en, 1);
        chk("abt_t0_addr", wr_addr, 132);
        step();
        chk("abt_t1_addr", wr_addr, 133);
        clear_req = 1'b1; step(); clear_req = 1'b0;
        chk("abt_clr_en", wr_en, 1);
        chk("abt_clr_addr", wr_addr, 0);
        chk("abt_clr_data", wr_data, 0);
        chk("abt_clr_busy", busy, 1);
        repeat (10) step();
        clear_req = 1'b1; step(); clear_req = 1'b0;
        chk("clr_ignored_addr", wr_addr, 11);
        submit_req = 1'b1; step(); submit_req = 1'b0;
        repeat (488) step();
        chk("pre_rst_addr", wr_addr, 500);

        // asynchronous reset mid-sweep, then a normal first cycle after release
        #2 rst = 1'b1;
        #1;
        chk("arst_wr_en", wr_en, 0);
        chk("arst_wr_addr", wr_addr, 0);
        chk("arst_wr_data", wr_data, 0);
        chk("arst_end_write", end_write, 0);
        chk("arst_busy", busy, 0);
        step(); step();
        rst = 1'b0; cursor_x = 2; cursor_y = 0; pen_down = 1'b1;
        step();
        pen_down = 1'b0;
        chk("post_rst_en", wr_en, 1);
        chk("post_rst_addr", wr_addr, 2);
        step();
        errs = 0;
        for (int n = 0; n < 50; n++) begin
            if (wr_en !== 1'b0 || end_write !== 1'b0 || busy !== 1'b0) errs++;
            step();
        end
        chk("post_rst_quiet", errs, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
